// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the upstream requesters, the arbiter and the shared
// memory port. The request/response record types live here so every user of
// the bundle sees the same layout.
//   slave  : arbiter view (consumes requests and memory responses)
//   master : environment view (requesters plus shared memory)
interface mem_bus_arbiter_if #(
   parameter int NUM_REQ = 2
);

   // One upstream or downstream request beat.
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   // Response from memory: address phase done, data phase done, read data.
   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

   dbus_req_t  ireq  [NUM_REQ];
   dbus_resp_t iresp [NUM_REQ];
   dbus_req_t  oreq;
   dbus_resp_t oresp;

   modport slave (
      input  ireq,
      input  oresp,
      output iresp,
      output oreq
   );

   modport master (
      output ireq,
      output oresp,
      input  iresp,
      input  oreq
   );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream data-bus port between NUM_REQ upstream requesters.
// One requester is granted at a time; its request is latched and held on the
// shared port until memory signals data_ok, and the memory response is routed
// back to the granted requester only.
//
// Optional feature: define MEM_BUS_ARB_RR_EN for round-robin arbitration
// (search starts one past the last completed grant). Without it the lowest
// valid index always wins; last_grant is still tracked but not consulted.
module mem_bus_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   mem_bus_arbiter_if.slave bus,
   output logic             busy,
   output logic [IDX_W-1:0] grant_idx
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] last_grant;
   logic [NUM_REQ-1:0] req_valid;
   logic             any_valid;
   logic [IDX_W-1:0] winner;

   // Lowest valid index wins.
   function automatic logic [IDX_W-1:0] pick_fixed(input logic [NUM_REQ-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // First valid index at or after last+1, wrapping at NUM_REQ; the requester
   // that just completed is examined last.
   function automatic logic [IDX_W-1:0] pick_rr(input logic [NUM_REQ-1:0] v,
                                                input logic [IDX_W-1:0]   last);
      logic [IDX_W-1:0] r;
      int               idx;
      r = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (v[idx]) r = IDX_W'(idx);
      end
      return r;
   endfunction

   // Collect the valid bits of all upstream requests.
   always_comb begin
      req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = bus.ireq[i].valid;
      end
      any_valid = |req_valid;
   end

`ifdef MEM_BUS_ARB_RR_EN
   assign winner = pick_rr(req_valid, last_grant);
`else
   logic [IDX_W-1:0] unused_last_grant;
   assign unused_last_grant = last_grant;
   assign winner = pick_fixed(req_valid);
`endif

   // Grant/complete state machine; bus.oreq is the latched request register,
   // so the downstream port is driven straight from flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant_idx  <= '0;
         last_grant <= IDX_W'(NUM_REQ - 1);
         bus.oreq   <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  bus.oreq       <= bus.ireq[winner];
                  bus.oreq.valid <= 1'b1;
                  grant_idx      <= winner;
                  busy           <= 1'b1;
                  state          <= BUSY;
               end
            end
            BUSY: begin
               // addr_ok alone does not end the transaction; only data_ok does.
               if (bus.oresp.data_ok) begin
                  bus.oreq   <= '0;
                  busy       <= 1'b0;
                  last_grant <= grant_idx;
                  state      <= IDLE;
               end
            end
         endcase
      end
   end

   // Forward the memory response to the granted requester only; responses
   // seen while IDLE are dropped.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.iresp[i] = '0;
         if ((state == BUSY) && (grant_idx == IDX_W'(i))) begin
            bus.iresp[i] = bus.oresp;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter. Expected grants and responses are
// queued when stimulus is issued; a monitor pops them when the DUT shows a new
// downstream request or a data_ok on an upstream response port.
module tb_mem_bus_arbiter;

   localparam int NUM_REQ = 2;
   localparam int IDX_W   = 1;

   logic             clk;
   logic             reset;
   logic             busy;
   logic [IDX_W-1:0] grant_idx;

   mem_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   mem_bus_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   typedef struct {
      int          idx;
      logic [31:0] val;
   } exp_t;

   exp_t gq[$];
   exp_t rq[$];

   int          checks   = 0;
   int          failures = 0;
   int          lat_addr = 0;
   int          lat_data = 0;
   logic [31:0] mem_data = '0;
   logic        spur     = 1'b0;
   logic        chk_gap  = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t mk(input int idx, input logic [31:0] val);
      exp_t e;
      e.idx = idx;
      e.val = val;
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic wait_grant(input int bound);
      int n;
      n = 0;
      while (!bus.oreq.valid && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("wait_grant", bus.oreq.valid, 1);
   endtask

   task automatic wait_resp(input int i, input int bound);
      int n;
      n = 0;
      while (!bus.iresp[i].data_ok && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("wait_resp", bus.iresp[i].data_ok, 1);
   endtask

   task automatic set_req(input int i, input logic [31:0] addr);
      bus.ireq[i].valid  = 1'b1;
      bus.ireq[i].addr   = addr;
      bus.ireq[i].size   = 3'd2;
      bus.ireq[i].strobe = 4'h0;
      bus.ireq[i].data   = 32'h0;
   endtask

   // Shared memory model: counts cycles of oreq.valid and raises addr_ok and
   // data_ok in the configured cycles; spur forces a response regardless.
   initial begin
      int cnt;
      cnt = 0;
      bus.oresp = '0;
      forever begin
         @(posedge clk);
         #1;
         cnt = bus.oreq.valid ? cnt + 1 : 0;
         bus.oresp.addr_ok = ((cnt != 0) && (cnt == lat_addr)) || spur;
         bus.oresp.data_ok = ((cnt != 0) && (cnt == lat_data)) || spur;
         bus.oresp.data    = bus.oresp.data_ok ? mem_data : 32'h0;
      end
   end

   // Monitor: grant starts, response routing, quiet ports, idle gap.
   initial begin
      logic prev_v;
      logic gap_armed;
      int   idle_run;
      exp_t e;
      prev_v    = 1'b0;
      gap_armed = 1'b0;
      idle_run  = 0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            if (bus.oreq.valid && !prev_v) begin
               if (chk_gap && gap_armed) check("idle_gap", 64'(idle_run), 1);
               gap_armed = chk_gap;
               if (gq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_grant actual=%0d required=none", grant_idx);
               end else begin
                  e = gq.pop_front();
                  check("grant_idx", 64'(grant_idx), 64'(e.idx));
                  check("oreq_addr", 64'(bus.oreq.addr), 64'(e.val));
                  check("busy_on_grant", 64'(busy), 1);
               end
            end
            if (!chk_gap) gap_armed = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!busy || (int'(grant_idx) != i)) begin
                  check("iresp_quiet",
                        64'({bus.iresp[i].addr_ok, bus.iresp[i].data_ok, bus.iresp[i].data}), 0);
               end
               if (bus.iresp[i].data_ok) begin
                  if (rq.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_resp actual=port%0d required=none", i);
                  end else begin
                     e = rq.pop_front();
                     check("resp_port", 64'(i), 64'(e.idx));
                     check("resp_data", 64'(bus.iresp[i].data), 64'(e.val));
                  end
               end
            end
            idle_run = bus.oreq.valid ? 0 : idle_run + 1;
         end else begin
            idle_run = 0;
         end
         prev_v = bus.oreq.valid;
      end
   end

   // Directed stimulus.
   initial begin
      int done;
      int n;
      int exp_order [5];
      reset = 1'b0;
      bus.ireq[0] = '0;
      bus.ireq[1] = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_oreq_valid", 64'(bus.oreq.valid), 0);
      check("rst_oreq_addr", 64'(bus.oreq.addr), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_grant_idx", 64'(grant_idx), 0);
      reset = 1'b1;

      // Single request on port 1, memory answers in BUSY cycle 4
      @(posedge clk); #1;
      lat_addr = 4;
      lat_data = 4;
      mem_data = 32'hDEAD_BEEF;
      gq.push_back(mk(1, 32'h8000_0010));
      rq.push_back(mk(1, 32'hDEAD_BEEF));
      set_req(1, 32'h8000_0010);
      @(negedge clk);
      check("t1_valid_cycle_n", 64'(bus.oreq.valid), 0);
      @(negedge clk);
      check("t1_valid_cycle_n1", 64'(bus.oreq.valid), 1);
      wait_resp(1, 20);
      bus.ireq[1].valid = 1'b0;
      repeat (2) @(negedge clk);

      // Both requesters valid, 2-cycle transactions
`ifdef MEM_BUS_ARB_RR_EN
      exp_order = '{0, 1, 0, 1, 1};
`else
      exp_order = '{0, 0, 0, 0, 1};
`endif
      @(posedge clk); #1;
      lat_addr = 1;
      lat_data = 2;
      mem_data = 32'h0BAD_F00D;
      chk_gap  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         gq.push_back(mk(exp_order[k], (exp_order[k] == 0) ? 32'h1000_0000 : 32'h2000_0004));
         rq.push_back(mk(exp_order[k], 32'h0BAD_F00D));
      end
      set_req(0, 32'h1000_0000);
      set_req(1, 32'h2000_0004);
      done = 0;
      n    = 0;
      while (done < 5 && n < 100) begin
         @(negedge clk);
         n++;
         if (bus.iresp[0].data_ok || bus.iresp[1].data_ok) begin
            if (bus.iresp[1].data_ok && done >= 4) bus.ireq[1].valid = 1'b0;
            done++;
            if (done == 4) bus.ireq[0].valid = 1'b0;
         end
      end
      check("t2_completions", 64'(done), 5);
      chk_gap = 1'b0;
      repeat (2) @(negedge clk);

      // Split handshake with a request change while BUSY
      @(posedge clk); #1;
      lat_addr = 2;
      lat_data = 5;
      mem_data = 32'h5151_A0A0;
      gq.push_back(mk(0, 32'h3000_0040));
      rq.push_back(mk(0, 32'h5151_A0A0));
      set_req(0, 32'h3000_0040);
      wait_grant(10);
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) @(negedge clk);
         check("t3_busy", 64'(busy), 1);
         check("t3_oreq_addr", 64'(bus.oreq.addr), 64'h3000_0040);
         check("t3_addr_ok", 64'(bus.iresp[0].addr_ok), 64'(k == 2));
         check("t3_data_ok", 64'(bus.iresp[0].data_ok), 64'(k == 5));
         if (k == 2) bus.ireq[0].addr = 32'h3000_0FFC;
      end
      bus.ireq[0].valid = 1'b0;
      @(negedge clk);
      check("t3_idle_busy", 64'(busy), 0);
      check("t3_idle_valid", 64'(bus.oreq.valid), 0);
      repeat (2) @(negedge clk);

      // Reset asserted between edges during BUSY
      @(posedge clk); #1;
      lat_addr = 0;
      lat_data = 0;
      gq.push_back(mk(1, 32'h4000_0000));
      set_req(1, 32'h4000_0000);
      wait_grant(10);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("t4_rst_valid", 64'(bus.oreq.valid), 0);
      check("t4_rst_busy", 64'(busy), 0);
      check("t4_rst_grant_idx", 64'(grant_idx), 0);
      bus.ireq[1].valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      lat_addr = 2;
      lat_data = 2;
      mem_data = 32'h7777_0001;
      gq.push_back(mk(1, 32'h4000_0100));
      rq.push_back(mk(1, 32'h7777_0001));
      set_req(1, 32'h4000_0100);
      wait_grant(10);
      wait_resp(1, 10);
      bus.ireq[1].valid = 1'b0;
      repeat (2) @(negedge clk);

      // Spurious response while IDLE
      mem_data = 32'hFFFF_0000;
      spur     = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t5_busy", 64'(busy), 0);
         check("t5_oreq_valid", 64'(bus.oreq.valid), 0);
         check("t5_iresp0", 64'({bus.iresp[0].addr_ok, bus.iresp[0].data_ok}), 0);
         check("t5_iresp1", 64'({bus.iresp[1].addr_ok, bus.iresp[1].data_ok}), 0);
      end
      spur = 1'b0;
      @(negedge clk);
      check("t5_after_busy", 64'(busy), 0);

      repeat (2) @(negedge clk);
      check("grant_queue_empty", 64'(gq.size()), 0);
      check("resp_queue_empty", 64'(rq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "time limit");
   end

endmodule
